// File: rtl/enc4_pkg.sv
// Shared definitions for the function-4 cipher path (encrypt and decrypt ends).
// Widths, LFSR taps, packet layout and the mask4 keystream expansion.
package enc4_pkg;

  localparam int unsigned PT_W  = 60;
  localparam int unsigned KEY_W = 11;
  localparam int unsigned SUM_W = 61;
  localparam int unsigned TAG_W = 6;
  localparam int unsigned PKT_W = 78;

  // x^11 + x^9 + 1 : feedback from bits 10 and 8
  localparam int unsigned LFSR_TAP_HI = 10;
  localparam int unsigned LFSR_TAP_LO = 8;

  typedef logic [KEY_W-1:0] key_t;

  typedef struct packed {
    key_t             key;
    logic [SUM_W-1:0] sum;
    logic [TAG_W-1:0] tag;
  } pkt_t;

  function automatic logic [PT_W-1:0] mask4(input key_t k);
    return {k[4:0], ~k, k, ~k, ~k, k};
  endfunction

  function automatic key_t lfsr_next(input key_t r);
    return {r[KEY_W-2:0], r[LFSR_TAP_HI] ^ r[LFSR_TAP_LO]};
  endfunction

  function automatic key_t lfsr_coerce(input key_t v);
    return (v == '0) ? key_t'(1) : v;
  endfunction

endpackage

// File: rtl/enc4_lfsr.sv
// 11-bit keystream LFSR: steps on i_step, reloads on i_load (load wins),
// zero seeds are coerced to 1 so the all-zero lock-up state is unreachable.
module enc4_lfsr
  import enc4_pkg::*;
#(
  parameter key_t SEED = 11'h001
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic i_step,
  input  logic i_load,
  input  key_t i_load_value,
  output key_t o_key
);

  localparam key_t SEED_C = lfsr_coerce(SEED);

  key_t r_key;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_key <= SEED_C;
    end else if (i_load) begin
      r_key <= lfsr_coerce(i_load_value);
    end else if (i_step) begin
      r_key <= lfsr_next(r_key);
    end
  end

  assign o_key = r_key;

endmodule

// File: rtl/encrypt_function_4_stream.sv
// Two-stage streaming encryptor for cipher function 4: y = x + mask4(key).
// Optional runtime reseed ports when ENC4_SEED_LOAD_EN is defined.
module encrypt_function_4_stream
  import enc4_pkg::*;
#(
  parameter logic [10:0] SEED    = 11'h001,
  parameter logic [5:0]  FUNC_ID = 6'h04
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [59:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [77:0] out_data
`ifdef ENC4_SEED_LOAD_EN
  ,
  input  logic        seed_load,
  input  logic [10:0] seed_value
`endif
);

  logic             w_seed_load;
  key_t             w_seed_value;
  key_t             w_key;
  logic             w_s2_load;
  logic             w_in_ready;
  logic             w_accept;
  logic [SUM_W-1:0] w_sum;

  logic             r_s1_valid;
  logic [PT_W-1:0]  r_s1_x;
  key_t             r_s1_key;
  logic             r_s2_valid;
  pkt_t             r_s2_pkt;

`ifdef ENC4_SEED_LOAD_EN
  assign w_seed_load  = seed_load;
  assign w_seed_value = seed_value;
`else
  assign w_seed_load  = 1'b0;
  assign w_seed_value = '0;
`endif

  assign w_s2_load  = !r_s2_valid || out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_load;
  assign w_accept   = in_valid && w_in_ready;

  enc4_lfsr #(
    .SEED(SEED)
  ) u_lfsr (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .i_step      (w_accept),
    .i_load      (w_seed_load),
    .i_load_value(w_seed_value),
    .o_key       (w_key)
  );

  // Mask is consumed only by the adder, so it is folded into the S2 sum register.
  assign w_sum = {1'b0, r_s1_x} + {1'b0, mask4(r_s1_key)};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_key   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_pkt   <= '0;
    end else begin
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_pkt <= '{key: r_s1_key, sum: w_sum, tag: FUNC_ID};
        end
      end
      if (w_in_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_x   <= in_data;
          r_s1_key <= w_key;
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_pkt;

endmodule

// File: tb/tb_encrypt_function_4_stream.sv
// Self-checking bench for encrypt_function_4_stream: scoreboard model plus
// directed literal checks; exercises reseed ports when ENC4_SEED_LOAD_EN is set.
module tb_encrypt_function_4_stream;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [59:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [77:0] out_data;
`ifdef ENC4_SEED_LOAD_EN
  logic        seed_load = 1'b0;
  logic [10:0] seed_value = '0;
`endif

  int errors = 0;
  int checks = 0;

  encrypt_function_4_stream #(
    .SEED   (11'h001),
    .FUNC_ID(6'h04)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef ENC4_SEED_LOAD_EN
    ,
    .seed_load (seed_load),
    .seed_value(seed_value)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [77:0] act, input logic [77:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: mask written as 11-bit fields, inverted in fields 1,2,4.
  function automatic logic [59:0] m_mask(input logic [10:0] k);
    logic [59:0] m;
    for (int i = 0; i < 60; i++) begin
      int f;
      int j;
      f = i / 11;
      j = i % 11;
      m[i] = k[j] ^ ((f == 1) || (f == 2) || (f == 4));
    end
    return m;
  endfunction

  function automatic logic [77:0] m_pkt(input logic [59:0] x, input logic [10:0] k);
    logic [60:0] y;
    y = 61'(x) + 61'(m_mask(k));
    return {k, y, 6'h04};
  endfunction

  function automatic logic [10:0] m_step(input logic [10:0] r);
    return ((r << 1) | 11'(((r >> 10) ^ (r >> 8)) & 11'd1));
  endfunction

  logic [77:0] exp_q[$];
  logic [77:0] got[$];
  logic [10:0] m_key = 11'h001;
  bit          prev_stall = 1'b0;
  logic [77:0] prev_data;

  always @(negedge Clk) begin
    if (!Rst_n) begin
      exp_q.delete();
      m_key = 11'h001;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 78'(out_valid), 78'd1);
        chk("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 78'(out_valid), 78'd0);
        end else begin
          chk("pkt", out_data, exp_q.pop_front());
        end
        got.push_back(out_data);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
`ifdef ENC4_SEED_LOAD_EN
      if (in_valid && in_ready) exp_q.push_back(m_pkt(in_data, m_key));
      if (seed_load) m_key = (seed_value == 11'h000) ? 11'h001 : seed_value;
      else if (in_valid && in_ready) m_key = m_step(m_key);
`else
      if (in_valid && in_ready) begin
        exp_q.push_back(m_pkt(in_data, m_key));
        m_key = m_step(m_key);
      end
`endif
    end
  end

  task automatic do_reset();
    @(posedge Clk); #1;
    Rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    got.delete();
  endtask

  task automatic send(input logic [59:0] x);
    int n;
    bit acc;
    n = 0;
    in_valid = 1'b1;
    in_data = x;
    do begin
      @(negedge Clk);
      acc = in_ready;
      @(posedge Clk); #1;
      n++;
    end while (!acc && n < 400);
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 78'd0, 78'd1);
  endtask

  task automatic wait_got(input int n);
    int b;
    b = 0;
    while (got.size() < n && b < 500) begin
      @(posedge Clk);
      b++;
    end
    #1;
    chk("wait_out_count", 78'(got.size()), 78'(n));
  endtask

  logic [77:0] hold;
  logic [59:0] bp_words[4];
  int          idx;
  bit          acc;
  bit          rnd_done;
  int          per_bad;

  initial begin
    // Reset state
    #3;
    chk("rst_out_valid", 78'(out_valid), 78'd0);
    chk("rst_out_data", out_data, 78'd0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    chk("rst_in_ready", 78'(in_ready), 78'd1);

    // First word: literal packet, one edge after the accepting edge
    out_ready = 1'b1;
    send(60'h0);
    chk("lat_not_yet", 78'(out_valid), 78'd0);
    @(posedge Clk); #1;
    chk("lat_valid", 78'(out_valid), 78'd1);
    chk("first_pkt", out_data, {11'h001, 61'h0_0FFE_003F_FBFF_001, 6'h04});
    send(60'h0);
    send(60'h0);
    wait_got(3);
    chk("key2", 78'(got[1][77:67]), 78'h002);
    chk("key3", 78'(got[2][77:67]), 78'h004);

    // Carry into bit 60
    do_reset();
    send(60'hFFF_FFFF_FFFF_FFFF);
    wait_got(1);
    chk("carry_sum", 78'(got[0][66:6]), 78'(61'h1_0FFE_003F_FBFF_000));

    // Back-pressure
    do_reset();
    bp_words[0] = 60'h123_4567_89AB_CDEF;
    bp_words[1] = 60'hFED_CBA9_8765_4321;
    bp_words[2] = 60'h0F0_F0F0_F0F0_F0F0;
    bp_words[3] = 60'hAAA_AAAA_5555_5555;
    out_ready = 1'b0;
    idx = 0;
    in_valid = 1'b1;
    in_data = bp_words[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      acc = in_ready;
      if (c == 2) begin
        chk("bp_in_ready_low", 78'(in_ready), 78'd0);
        hold = out_data;
      end
      if (c == 4) chk("bp_stable", out_data, hold);
      @(posedge Clk); #1;
      if (acc) begin
        idx++;
        in_data = bp_words[idx];
      end
    end
    in_valid = 1'b0;
    chk("bp_accepted", 78'(idx), 78'd2);
    out_ready = 1'b1;
    for (int k = 2; k < 4; k++) send(bp_words[k]);
    wait_got(4);
    chk("bp_key0", 78'(got[0][77:67]), 78'h001);
    chk("bp_key1", 78'(got[1][77:67]), 78'h002);
    chk("bp_key2", 78'(got[2][77:67]), 78'h004);
    chk("bp_key3", 78'(got[3][77:67]), 78'h008);

    // Random stream with stalls
    do_reset();
    rnd_done = 1'b0;
    fork
      begin
        for (int w = 0; w < 3000; w++) begin
          repeat ($urandom_range(0, 1)) begin
            @(posedge Clk); #1;
          end
          send({$urandom(), $urandom()} & 60'hFFF_FFFF_FFFF_FFFF);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge Clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_got(3000);
    per_bad = 0;
    for (int i = 1; i < got.size(); i++) begin
      if (i < 2047 && got[i][77:67] == got[0][77:67]) per_bad++;
      if (i >= 2047 && got[i][77:67] != got[i-2047][77:67]) per_bad++;
    end
    chk("key_period_2047", 78'(per_bad), 78'd0);

    // Reset with two words in flight
    do_reset();
    out_ready = 1'b0;
    send(60'h111);
    send(60'h222);
    chk("inflight_valid", 78'(out_valid), 78'd1);
    Rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 78'(out_valid), 78'd0);
    chk("async_rst_data", out_data, 78'd0);
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    got.delete();
    out_ready = 1'b1;
    send(60'h333);
    wait_got(1);
    chk("post_rst_key", 78'(got[0][77:67]), 78'h001);

`ifdef ENC4_SEED_LOAD_EN
    // Runtime reseed, including the zero-coercion case
    do_reset();
    send(60'h1);
    send(60'h2);
    seed_load = 1'b1;
    seed_value = 11'h000;
    @(posedge Clk); #1;
    seed_load = 1'b0;
    send(60'h3);
    seed_load = 1'b1;
    seed_value = 11'h155;
    @(posedge Clk); #1;
    seed_load = 1'b0;
    send(60'h4);
    wait_got(4);
    chk("seed_zero_key", 78'(got[2][77:67]), 78'h001);
    chk("seed_155_key", 78'(got[3][77:67]), 78'h155);
`endif

    repeat (3) @(posedge Clk);
    chk("model_drained", 78'(exp_q.size()), 78'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
